// File: rtl/pulse_pkg.sv
// Shared types for the pulse sequencer: field widths, command record, FSM states.
package pulse_pkg;

    localparam int WIDTH_W = 11;
    localparam int NUM_W   = 11;
    localparam int GAP_W   = 16;
    localparam int LVL_W   = 5;
    localparam int CNT_W   = 16;

    typedef struct packed {
        logic [WIDTH_W-1:0] width;
        logic [NUM_W-1:0]   num;
        logic [GAP_W-1:0]   gap;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_STROBE    = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    // A command with any zero field would program a meaningless train.
    function automatic logic cmd_is_zero(input cmd_t c);
        return (c.width == '0) || (c.num == '0) || (c.gap == '0);
    endfunction

endpackage

// File: rtl/pulse_cmd_fifo.sv
// Synchronous DEPTH-entry command FIFO with flush; flush overrides push and pop.
module pulse_cmd_fifo
    import pulse_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  cmd_t             din,
    output cmd_t             dout,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Full blocks pushes outright, even when a pop happens on the same edge.
    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/pulse_seq.sv
// Queues pulse-train commands and launches them one at a time into the pulse
// generator: pop, hold start_o for STROBE_LEN cycles, then wait for done_i.
module pulse_seq
    import pulse_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STROBE_LEN = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [WIDTH_W-1:0] cmd_width_i,
    input  logic [NUM_W-1:0]   cmd_num_i,
    input  logic [GAP_W-1:0]   cmd_gap_us_i,
    input  logic               enable_i,
    input  logic               abort_i,
    input  logic               err_clr_i,
    output logic [WIDTH_W-1:0] pulse_width_o,
    output logic [NUM_W-1:0]   pulse_num_o,
    output logic [GAP_W-1:0]   gap_us_o,
    output logic               start_o,
    input  logic               done_i,
    output logic               busy_o,
    output logic [LVL_W-1:0]   level_o,
    output logic [CNT_W-1:0]   done_cnt_o,
    output logic               err_o
);

    state_t           state_q, state_d;
    cmd_t             pulse_q, pulse_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic [3:0]       scnt_q, scnt_d;
    logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
    logic             err_q, err_d;
    logic             rdy_en_q;

    cmd_t cmd_in;
    cmd_t head;
    logic full, empty, pop, hs, zero, fifo_push;

    assign cmd_in    = {cmd_width_i, cmd_num_i, cmd_gap_us_i};
    assign zero      = cmd_is_zero(cmd_in);
    // Ready is held low through reset and rises on the first edge after it.
    assign cmd_ready_o = rdy_en_q & ~full;
    assign hs        = cmd_valid_i & cmd_ready_o;
    assign fifo_push = hs & ~zero;

    pulse_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (pop),
        .flush (abort_i),
        .din   (cmd_in),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level_o)
    );

    // Next-state and next-output logic; abort wins over every state.
    always_comb begin
        state_d    = state_q;
        pulse_d    = pulse_q;
        start_d    = start_q;
        busy_d     = busy_q;
        scnt_d     = scnt_q;
        done_cnt_d = done_cnt_q;
        pop        = 1'b0;
        if (abort_i) begin
            state_d = S_IDLE;
            start_d = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (!empty && enable_i) begin
                    pop     = 1'b1;
                    pulse_d = head;
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                    scnt_d  = '0;
                    state_d = S_STROBE;
                end
                S_STROBE: if (scnt_q == 4'(STROBE_LEN - 1)) begin
                    start_d = 1'b0;
                    state_d = S_WAIT_DONE;
                end else begin
                    scnt_d = scnt_q + 4'd1;
                end
                S_WAIT_DONE: if (done_i) begin
                    busy_d     = 1'b0;
                    done_cnt_d = done_cnt_q + CNT_W'(1);
                    state_d    = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Sticky error: a fresh zero-field handshake beats a same-cycle clear.
    always_comb begin
        err_d = err_q;
        if (err_clr_i) err_d = 1'b0;
        if (hs && zero) err_d = 1'b1;
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pulse_q    <= '0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            scnt_q     <= '0;
            done_cnt_q <= '0;
            err_q      <= 1'b0;
            rdy_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pulse_q    <= pulse_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            scnt_q     <= scnt_d;
            done_cnt_q <= done_cnt_d;
            err_q      <= err_d;
            rdy_en_q   <= 1'b1;
        end
    end

    assign pulse_width_o = pulse_q.width;
    assign pulse_num_o   = pulse_q.num;
    assign gap_us_o      = pulse_q.gap;
    assign start_o       = start_q;
    assign busy_o        = busy_q;
    assign done_cnt_o    = done_cnt_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_pulse_seq.sv
// Directed bench for pulse_seq with hand-computed expectations.
module tb_pulse_seq;
    import pulse_pkg::*;

    localparam int DEPTH = 4;
    localparam int SL    = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cmd_valid_i = 1'b0;
    logic               cmd_ready_o;
    logic [WIDTH_W-1:0] cmd_width_i = '0;
    logic [NUM_W-1:0]   cmd_num_i = '0;
    logic [GAP_W-1:0]   cmd_gap_us_i = '0;
    logic               enable_i = 1'b0;
    logic               abort_i = 1'b0;
    logic               err_clr_i = 1'b0;
    logic [WIDTH_W-1:0] pulse_width_o;
    logic [NUM_W-1:0]   pulse_num_o;
    logic [GAP_W-1:0]   gap_us_o;
    logic               start_o;
    logic               done_i = 1'b0;
    logic               busy_o;
    logic [LVL_W-1:0]   level_o;
    logic [CNT_W-1:0]   done_cnt_o;
    logic               err_o;

    pulse_seq #(.DEPTH(DEPTH), .STROBE_LEN(SL)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_width_i   (cmd_width_i),
        .cmd_num_i     (cmd_num_i),
        .cmd_gap_us_i  (cmd_gap_us_i),
        .enable_i      (enable_i),
        .abort_i       (abort_i),
        .err_clr_i     (err_clr_i),
        .pulse_width_o (pulse_width_o),
        .pulse_num_o   (pulse_num_o),
        .gap_us_o      (gap_us_o),
        .start_o       (start_o),
        .done_i        (done_i),
        .busy_o        (busy_o),
        .level_o       (level_o),
        .done_cnt_o    (done_cnt_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one command for a single edge.
    task automatic push(input logic [10:0] w, input logic [10:0] n, input logic [15:0] g);
        cmd_valid_i  = 1'b1;
        cmd_width_i  = w;
        cmd_num_i    = n;
        cmd_gap_us_i = g;
        tick();
        cmd_valid_i  = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int k = 0;
        while (!start_o && k < 40) begin
            tick();
            k++;
        end
        chk(tag, start_o, 1);
    endtask

    // Called on the first cycle start_o is high: checks parameters, strobe
    // length, then completes the train after 'gap' further cycles.
    task automatic train(input logic [10:0] w, input logic [10:0] n, input logic [15:0] g,
                         input int gap);
        chk("pulse_width", pulse_width_o, w);
        chk("pulse_num", pulse_num_o, n);
        chk("gap_us", gap_us_o, g);
        chk("busy_strobe", busy_o, 1);
        for (int i = 1; i < SL; i++) begin
            tick();
            chk("start_held", start_o, 1);
        end
        tick();
        chk("start_fall", start_o, 0);
        chk("busy_wait", busy_o, 1);
        repeat (gap) tick();
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        chk("busy_after_done", busy_o, 0);
    endtask

    initial begin
        // Reset values while rst is held
        #1;
        chk("rst_ready", cmd_ready_o, 0);
        chk("rst_start", start_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_level", level_o, 0);
        chk("rst_done_cnt", done_cnt_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_width", pulse_width_o, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("ready_after_rst", cmd_ready_o, 1);

        // Single train: push at edge N, start visible after N+1
        enable_i = 1'b1;
        push(11'd20, 11'd3, 16'd5);
        chk("t1_level", level_o, 1);
        chk("t1_start_early", start_o, 0);
        tick();
        chk("t1_start_n1", start_o, 1);
        chk("t1_level_popped", level_o, 0);
        train(11'd20, 11'd3, 16'd5, 100 - SL);
        chk("t1_done_cnt", done_cnt_o, 1);

        // Fill past capacity with launches disabled, then drain in order
        enable_i = 1'b0;
        for (int k = 1; k <= 5; k++)
            push(11'(100 + k), 11'(k), 16'(10 + k));
        chk("fill_level", level_o, 4);
        chk("fill_ready", cmd_ready_o, 0);
        chk("fill_no_start", start_o, 0);
        enable_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            wait_start("drain_start");
            train(11'(100 + k), 11'(k), 16'(10 + k), 2);
        end
        repeat (3) tick();
        chk("drain_no_fifth", start_o, 0);
        chk("drain_level", level_o, 0);
        chk("drain_done_cnt", done_cnt_o, 5);

        // Zero-field command dropped with sticky error
        push(11'd0, 11'd3, 16'd5);
        chk("zero_level", level_o, 0);
        chk("zero_err", err_o, 1);
        chk("zero_no_start", start_o, 0);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        chk("err_cleared", err_o, 0);
        err_clr_i = 1'b1;
        push(11'd11, 11'd0, 16'd7);
        err_clr_i = 1'b0;
        chk("err_set_wins", err_o, 1);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        chk("err_cleared2", err_o, 0);

        // Abort in WAIT_DONE with two entries still queued
        enable_i = 1'b0;
        push(11'd41, 11'd1, 16'd1);
        push(11'd42, 11'd2, 16'd2);
        push(11'd43, 11'd3, 16'd3);
        enable_i = 1'b1;
        tick();
        chk("ab_start", start_o, 1);
        chk("ab_level", level_o, 2);
        enable_i = 1'b0;
        repeat (SL) tick();
        chk("ab_wait_start_low", start_o, 0);
        chk("ab_wait_busy", busy_o, 1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("ab_level0", level_o, 0);
        chk("ab_busy0", busy_o, 0);
        chk("ab_start0", start_o, 0);
        chk("ab_width_held", pulse_width_o, 41);
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        chk("ab_late_done", done_cnt_o, 5);
        enable_i = 1'b1;
        repeat (3) tick();
        chk("ab_no_relaunch", start_o, 0);

        // Asynchronous reset during STROBE with queued entries and err set
        enable_i = 1'b0;
        push(11'd0, 11'd1, 16'd1);
        push(11'd31, 11'd1, 16'd1);
        push(11'd32, 11'd1, 16'd1);
        enable_i = 1'b1;
        tick();
        chk("rs_start", start_o, 1);
        #2 rst = 1'b1;
        #1;
        chk("rs_start0", start_o, 0);
        chk("rs_busy0", busy_o, 0);
        chk("rs_level0", level_o, 0);
        chk("rs_done_cnt0", done_cnt_o, 0);
        chk("rs_err0", err_o, 0);
        chk("rs_width0", pulse_width_o, 0);
        chk("rs_ready0", cmd_ready_o, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("rs_ready1", cmd_ready_o, 1);
        repeat (3) tick();
        chk("rs_idle_no_start", start_o, 0);
        chk("rs_queue_gone", level_o, 0);

        // Done counter wrap and spurious done in IDLE
        force dut.done_cnt_q = 16'hFFFF;
        tick();
        release dut.done_cnt_q;
        tick();
        chk("wrap_preload", done_cnt_o, 16'hFFFF);
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        chk("wrap_spurious", done_cnt_o, 16'hFFFF);
        push(11'd7, 11'd2, 16'd9);
        wait_start("wrap_start");
        train(11'd7, 11'd2, 16'd9, 3);
        chk("wrap_zero", done_cnt_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
